video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised raster timing generator that produces the horizontal and vertical pixel counters, sync, blanking and data-enable signals for the VGA output path.
- Generalises the standalone vertical counter: both axes, configurable sync polarity, a frame counter and line/frame strobes.
- Timing can be reprogrammed at runtime through shadow registers that take effect only at a frame boundary, so the raster never tears.
- Sits between the pixel-clock-enable source and the pixel/matrix renderer, which consumes `h_count`, `v_count` and `de`.

Parameters:
- CNT_W, 12 — width of the h/v counters and of every timing field.
- H_ACTIVE, 640 — default visible pixels per line.
- H_FP, 16 — default horizontal front porch.
- H_SYNC, 96 — default hsync pulse width.
- H_BP, 48 — default horizontal back porch.
- V_ACTIVE, 480 — default visible lines.
- V_FP, 10 — default vertical front porch.
- V_SYNC, 2 — default vsync width.
- V_BP, 33 — default vertical back porch.
- HSYNC_POL, 0 — hsync asserted level (0 = active-low).
- VSYNC_POL, 0 — vsync asserted level.
- FRAME_W, 16 — frame counter width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- clk_en  in  1  pixel enable; counters advance only when high
- cfg_wr  in  1  write strobe for the shadow timing field
- cfg_sel  in  3  field select: 0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_BP
- cfg_data  in  CNT_W  field value
- cfg_pending  out  1  shadow differs from active config, awaiting frame boundary
- h_count  out  CNT_W  current pixel column
- v_count  out  CNT_W  current line
- hsync  out  1  horizontal sync, polarity per HSYNC_POL
- vsync  out  1  vertical sync, polarity per VSYNC_POL
- hblank  out  1  h_count >= active H_ACTIVE
- vblank  out  1  v_count >= active V_ACTIVE
- de  out  1  ~hblank & ~vblank
- line_start  out  1  h_count == 0
- frame_start  out  1  h_count == 0 and v_count == 0
- frame_count  out  FRAME_W  completed frames, modulo 2^FRAME_W

Behaviour:
- **Reset.** Takes effect at the next clk edge regardless of clk_en.
  - h_count, v_count and frame_count go to 0; cfg_pending goes to 0.
  - Active and shadow configs both load the parameter defaults; any pending shadow writes are discarded.
  - Resulting outputs: hsync/vsync at the inactive level, hblank=vblank=0, de=1, line_start=frame_start=1.
- **Totals.**
  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOT likewise, computed from the active config in CNT_W+2 bits.
  - The integrator guarantees each total is at most 2^CNT_W; this is not checked.
- **Counting.** Only on clk edges with clk_en=1; with clk_en=0 all state holds.
  - h_count increments and wraps to 0 after H_TOT-1.
  - v_count increments on the h wrap and wraps to 0 after V_TOT-1.
  - A wrap occurs at TOT-1, never at TOT, so the line period is exactly H_TOT.
- **Decode.** Combinational from the counters and the active config, so outputs have zero latency relative to the counters.
  - hsync is asserted for H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC; vsync uses the same form on the vertical axis.
  - Strobes are level signals for the whole enabled pixel period; they are held across clk_en=0 cycles.
- **Frame boundary event (FB).** clk_en=1 and h_count=H_TOT-1 and v_count=V_TOT-1.
  - Both counters go to 0 and frame_count increments.
  - If cfg_pending=1, the active config loads the shadow and cfg_pending clears.
- **Config write.** cfg_wr=1 updates the selected shadow field and sets cfg_pending; it is independent of clk_en.
  - Writes of 0 to H_ACTIVE, H_SYNC, V_ACTIVE or V_SYNC are ignored: shadow and cfg_pending are unchanged. Porches may be 0.
  - Multiple writes before an FB accumulate; the last write to a field wins.
- **Write coincident with FB.**
  - The active config loads the shadow contents from before the write.
  - The write then lands in the shadow and cfg_pending stays 1, so the new value applies at the following FB.
- **Why active config only changes at FB.** The counters can never exceed a newly applied total mid-frame; no out-of-range recovery logic is required.

Test Plan:
1. Defaults, clk_en=1 -> hsync low exactly for h 656..751, h wraps 799->0; vsync low for v 490..491, v wraps 524->0; frame_count 0->1 after 420000 cycles; de=1 only for h<640 and v<480.
2. clk_en high 1 cycle in 4, HSYNC_POL=1 -> counters move only on enabled cycles; frame period 1680000 clocks; hsync high for h 656..751; line_start held 4 clocks.
3. Mid-frame write sel=0 data=800 -> cfg_pending=1; h still wraps at 799 for the rest of the frame. After FB: h wraps at 959, hblank rises at h=800, hsync for h 816..911, cfg_pending=0.
4. Write sel=5 data=20 on the exact FB cycle -> current frame keeps V_FP=10 and cfg_pending stays 1. At the next FB: vsync moves to v 500..501, V_TOT=535.
5. Write sel=2 data=0 -> shadow unchanged, cfg_pending stays 0, timing unaffected.
6. Pending write, then reset at h=300, v=200 -> next edge gives h=v=frame_count=0, cfg_pending=0, default 800x525 timing retained.

Source files
------------

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster h/v counters with sync, blank, de and strobe decode.
// Timing fields are written to a shadow copy and become active only at a frame boundary.
module video_timing_gen #(
  parameter int CNT_W     = 12,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int FRAME_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               cfg_wr,
  input  logic [2:0]         cfg_sel,
  input  logic [CNT_W-1:0]   cfg_data,
  output logic               cfg_pending,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic               hsync,
  output logic               vsync,
  output logic               hblank,
  output logic               vblank,
  output logic               de,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);
  localparam int TW = CNT_W + 2;
  localparam logic [8*CNT_W-1:0] DEF = {CNT_W'(V_BP), CNT_W'(V_SYNC), CNT_W'(V_FP), CNT_W'(V_ACTIVE),
                                        CNT_W'(H_BP), CNT_W'(H_SYNC), CNT_W'(H_FP), CNT_W'(H_ACTIVE)};
  logic [CNT_W-1:0] act [8];
  logic [CNT_W-1:0] shd [8];
  logic [TW-1:0] hc, vc, h_sync_on, h_sync_off, h_tot, v_sync_on, v_sync_off, v_tot;
  logic h_last, v_last, fb, wr_ok;
  always_comb begin
    hc = TW'(h_count);
    vc = TW'(v_count);
    h_sync_on = TW'(act[0]) + TW'(act[1]);
    h_sync_off = h_sync_on + TW'(act[2]);
    h_tot = h_sync_off + TW'(act[3]);
    v_sync_on = TW'(act[4]) + TW'(act[5]);
    v_sync_off = v_sync_on + TW'(act[6]);
    v_tot = v_sync_off + TW'(act[7]);
    h_last = hc == h_tot - TW'(1);
    v_last = vc == v_tot - TW'(1);
    fb = clk_en && h_last && v_last;
    // active widths and sync widths (even selects) must never be zero
    wr_ok = cfg_wr && (cfg_sel[0] || cfg_data != '0);
  end
  assign hblank      = hc >= TW'(act[0]);
  assign vblank      = vc >= TW'(act[4]);
  assign de          = !hblank && !vblank;
  assign hsync       = (hc >= h_sync_on && hc < h_sync_off) == (HSYNC_POL != 0);
  assign vsync       = (vc >= v_sync_on && vc < v_sync_off) == (VSYNC_POL != 0);
  assign line_start  = h_count == '0;
  assign frame_start = line_start && v_count == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
      frame_count <= '0;
      cfg_pending <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        act[i] <= DEF[i*CNT_W +: CNT_W];
        shd[i] <= DEF[i*CNT_W +: CNT_W];
      end
    end else begin
      if (clk_en) begin
        h_count <= h_last ? '0 : h_count + CNT_W'(1);
        if (h_last) v_count <= v_last ? '0 : v_count + CNT_W'(1);
      end
      if (fb) frame_count <= frame_count + FRAME_W'(1);
      // a write on the boundary cycle lands after the copy, so it waits for the next frame
      if (fb && cfg_pending) begin
        for (int i = 0; i < 8; i++) act[i] <= shd[i];
        cfg_pending <= 1'b0;
      end
      if (wr_ok) begin
        shd[cfg_sel] <= cfg_data;
        cfg_pending <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard bench for video_timing_gen using a small raster
// (25x15 totals) so whole frames fit in a short run.
module tb_video_timing_gen;
  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8, VF = 2, VS = 2, VB = 3;
  logic clk = 1'b0;
  logic reset, clk_en, cfg_wr;
  logic [2:0] cfg_sel;
  logic [11:0] cfg_data, h_count, v_count;
  logic cfg_pending, hsync, vsync, hblank, vblank, de, line_start, frame_start;
  logic [15:0] frame_count;
  logic [47:0] got, exp_v;
  logic [47:0] sb [$];
  int checks = 0, errors = 0;
  int mh, mv, mp;
  logic [15:0] mf;
  int act [8];
  int shd [8];

  always #5 clk = ~clk;

  video_timing_gen #(
    .CNT_W(12), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1), .VSYNC_POL(0), .FRAME_W(16)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .cfg_wr(cfg_wr), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cfg_pending(cfg_pending), .h_count(h_count), .v_count(v_count),
    .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .de(de),
    .line_start(line_start), .frame_start(frame_start), .frame_count(frame_count)
  );

  assign got = {cfg_pending, h_count, v_count, hsync, vsync, hblank, vblank, de,
                line_start, frame_start, frame_count};

  function automatic logic [47:0] model_out();
    logic hb, vb, hs, vs;
    hb = mh >= act[0];
    vb = mv >= act[4];
    hs = mh >= act[0] + act[1] && mh < act[0] + act[1] + act[2];
    vs = mv >= act[4] + act[5] && mv < act[4] + act[5] + act[6];
    return {mp[0], 12'(mh), 12'(mv), hs, !vs, hb, vb, !hb && !vb, mh == 0, mh == 0 && mv == 0, mf};
  endfunction

  function automatic bit at_fb();
    return mh == act[0] + act[1] + act[2] + act[3] - 1 && mv == act[4] + act[5] + act[6] + act[7] - 1;
  endfunction

  task automatic drive(input logic r, input logic e, input logic w, input logic [2:0] s, input logic [11:0] d);
    bit fb;
    @(negedge clk);
    reset = r; clk_en = e; cfg_wr = w; cfg_sel = s; cfg_data = d;
    if (r) begin
      mh = 0; mv = 0; mf = '0; mp = 0;
      act = '{HA, HF, HS, HB, VA, VF, VS, VB};
      shd = act;
    end else begin
      fb = e && at_fb();
      if (e) begin
        if (mh == act[0] + act[1] + act[2] + act[3] - 1) begin
          mh = 0;
          if (mv == act[4] + act[5] + act[6] + act[7] - 1) mv = 0;
          else mv++;
        end else mh++;
      end
      if (fb) mf++;
      if (fb && mp == 1) begin
        act = shd;
        mp = 0;
      end
      if (w && !(d == 0 && s[0] == 1'b0)) begin
        shd[s] = int'(d);
        mp = 1;
      end
    end
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    reset = 1'b0; cfg_wr = 1'b0;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0);
    exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL reset: got %h expected %h", got, exp_v); end
    checks++;
    if ({h_count, v_count, frame_count, cfg_pending, de, line_start, frame_start} !== {24'd0, 16'd0, 4'b0111}) begin
      errors++; $display("FAIL reset_const: h %0d v %0d f %0d pend %b de %b ls %b fs %b required 0 0 0 0 1 1 1",
                          h_count, v_count, frame_count, cfg_pending, de, line_start, frame_start);
    end
  endtask

  task automatic test_free_run();
    int first = -1, last = -1;
    for (int i = 0; i < 750; i++) begin
      drive(0, 1, 0, 0, 0);
      exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL free_run cyc %0d: got %h expected %h", i, got, exp_v); end
      if (v_count == 0 && hsync && first < 0) first = int'(h_count);
      if (v_count == 0 && hsync) last = int'(h_count);
    end
    checks++;
    if (first != 18 || last != 20) begin errors++; $display("FAIL hsync_window: got %0d..%0d required 18..20", first, last); end
    checks++;
    if (frame_count !== 16'd2) begin errors++; $display("FAIL frame_count: got %0d required 2", frame_count); end
  endtask

  task automatic test_clk_en();
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    for (int i = 0; i < 1500; i++) begin
      drive(0, i % 4 == 0, 0, 0, 0);
      exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL clk_en cyc %0d: got %h expected %h", i, got, exp_v); end
    end
    checks++;
    if ({frame_count, h_count, v_count} !== {16'd1, 24'd0}) begin
      errors++; $display("FAIL clk_en_period: f %0d h %0d v %0d required 1 0 0", frame_count, h_count, v_count);
    end
  endtask

  task automatic test_cfg_mid();
    int hmax = 0;
    for (int i = 0; i < 1200; i++) begin
      drive(0, 1, i == 100, 3'd0, 12'd20);
      exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL cfg_mid cyc %0d: got %h expected %h", i, got, exp_v); end
      if (frame_count >= 16'd3 && int'(h_count) > hmax) hmax = int'(h_count);
    end
    checks++;
    if (hmax != 28) begin errors++; $display("FAIL cfg_mid_wrap: got max h %0d required 28", hmax); end
  endtask

  task automatic test_cfg_at_fb();
    int n = 0;
    while (!at_fb() && n < 2000) begin
      drive(0, 1, 0, 0, 0);
      exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL cfg_fb_seek: got %h expected %h", got, exp_v); end
      n++;
    end
    checks++;
    if (n >= 2000) begin errors++; $display("FAIL cfg_fb_timeout: got %0d cycles required < 2000", n); end
    drive(0, 1, 1, 3'd5, 12'd4);
    exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL cfg_fb_edge: got %h expected %h", got, exp_v); end
    checks++;
    if (cfg_pending !== 1'b1) begin errors++; $display("FAIL cfg_fb_pending: got %b required 1", cfg_pending); end
    for (int i = 0; i < 1000; i++) begin
      drive(0, 1, 0, 0, 0);
      exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL cfg_fb cyc %0d: got %h expected %h", i, got, exp_v); end
    end
  endtask

  task automatic test_zero_write();
    drive(1, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(0, 1, 1, 3'd2, 12'd0);
    exp_v = sb.pop_front(); checks++;
    if (cfg_pending !== 1'b0) begin errors++; $display("FAIL zero_write_pending: got %b required 0", cfg_pending); end
    for (int i = 0; i < 400; i++) begin
      drive(0, 1, i == 5, 3'd6, 12'd0);
      exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL zero_write cyc %0d: got %h expected %h", i, got, exp_v); end
    end
  endtask

  task automatic test_reset_pending();
    drive(0, 1, 1, 3'd0, 12'd5);
    void'(sb.pop_front());
    for (int i = 0; i < 60; i++) begin
      drive(0, 1, 0, 0, 0);
      void'(sb.pop_front());
    end
    drive(1, 1, 0, 0, 0);
    exp_v = sb.pop_front(); checks++;
    if (got !== exp_v || cfg_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %h expected %h", got, exp_v); end
    for (int i = 0; i < 400; i++) begin
      drive(0, 1, 0, 0, 0);
      exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_default cyc %0d: got %h expected %h", i, got, exp_v); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0,
            3'($urandom_range(0, 7)), 12'($urandom_range(0, 12)));
      exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL random cyc %0d: got %h expected %h", i, got, exp_v); end
    end
  endtask

  initial begin
    reset = 1'b1; clk_en = 1'b0; cfg_wr = 1'b0; cfg_sel = '0; cfg_data = '0;
    test_reset();
    test_free_run();
    test_clk_en();
    test_cfg_mid();
    test_cfg_at_fb();
    test_zero_write();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
